// File: rtl/mul_seq_arb_if.sv
// mul_seq_arb_if -- request/grant/result bundle between two multiply
// requesters (testbench or Execute/coprocessor logic) and mul_seq_arb.
//
//   req[1:0]          request per port (bit p = port p)
//   pN_in0            multiplier operand (Rm), consumed 2 bits per cycle
//   pN_in1            multiplicand operand (Rs)
//   pN_acc            accumulate value (zero for plain multiply)
//   pN_long           1 = 64-bit result, 0 = 32-bit MUL/MLA
//   pN_signed         signed long multiply (ignored when pN_long = 0)
//   kill[1:0]         abort; only kill[owner] has an effect
//   gnt[1:0]          one-cycle pulse: operands of port p captured
//   done[1:0]         one-cycle pulse: result valid for port p
//   result[63:0]      product, held until the next done
//   res_n, res_z      negative / zero flags of result
//   busy              engine not idle
//   owner             port owning the current/last operation
interface mul_seq_arb_if;
   logic [1:0]  req;
   logic [31:0] p0_in0;
   logic [31:0] p1_in0;
   logic [31:0] p0_in1;
   logic [31:0] p1_in1;
   logic [63:0] p0_acc;
   logic [63:0] p1_acc;
   logic        p0_long;
   logic        p1_long;
   logic        p0_signed;
   logic        p1_signed;
   logic [1:0]  kill;
   logic [1:0]  gnt;
   logic [1:0]  done;
   logic [63:0] result;
   logic        res_n;
   logic        res_z;
   logic        busy;
   logic        owner;

   modport master (
      output req, p0_in0, p1_in0, p0_in1, p1_in1, p0_acc, p1_acc,
             p0_long, p1_long, p0_signed, p1_signed, kill,
      input  gnt, done, result, res_n, res_z, busy, owner
   );

   modport slave (
      input  req, p0_in0, p1_in0, p0_in1, p1_in1, p0_acc, p1_acc,
             p0_long, p1_long, p0_signed, p1_signed, kill,
      output gnt, done, result, res_n, res_z, busy, owner
   );
endinterface

// File: rtl/mul_seq_arb.sv
// mul_seq_arb -- shared radix-4 iterative multiplier with a two-port
// round-robin arbiter. Handles 32x32 MUL/MLA and 32x32->64
// UMULL/UMLAL/SMULL/SMLAL.
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   mul_seq_arb_if.slave (requests, operands, kill, gnt, done,
//         result, flags, busy, owner)
//
// Build option:
//   MULT_EARLY_TERM_EN  defined: iteration stops once the remaining
//                       multiplier bits are all zero (1..16 cycles).
//                       undefined: always 16 iterations (17 cycles
//                       accept-to-done). Results are identical.
module mul_seq_arb (
   input logic          clk,
   input logic          rst,
   mul_seq_arb_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

   state_t      state_q, state_d;
   logic        ptr_q, ptr_d;
   logic        owner_q, owner_d;
   logic [1:0]  gnt_q, gnt_d;
   logic [1:0]  done_q, done_d;
   logic [63:0] result_q, result_d;
   logic        res_n_q, res_n_d;
   logic        res_z_q, res_z_d;

   // Datapath registers carry no reset; they are always loaded on accept.
   logic [31:0] bf_q, bf_d;
   logic [31:0] in0_q, in0_d;
   logic [31:0] in1_q, in1_d;
   logic [63:0] mcand_q, mcand_d;
   logic [63:0] acc_q, acc_d;
   logic        long_q, long_d;
   logic        sgn_q, sgn_d;
`ifndef MULT_EARLY_TERM_EN
   logic [3:0]  cnt_q, cnt_d;
`endif

   // Unsigned partial products leave the signed long case off by
   // 2^32 * (in1*in0[31] + in0*in1[31]); remove that term here.
   // 32-bit operations drop the upper word entirely.
   function automatic logic [63:0] fixup(input logic [63:0] a,
                                         input logic [31:0] x,
                                         input logic [31:0] y,
                                         input logic        lng,
                                         input logic        sg);
      logic [63:0] corr;
      corr = (y[31] ? {x, 32'b0} : 64'b0) + (x[31] ? {y, 32'b0} : 64'b0);
      if (!lng)
         fixup = {32'b0, a[31:0]};
      else if (sg)
         fixup = a - corr;
      else
         fixup = a;
   endfunction

   // Round-robin winner: the pointer port if it asks, else the other one.
   logic        win;
   logic [31:0] w_in0, w_in1;
   logic [63:0] w_acc;
   logic        w_long, w_sgn;

   assign win    = bus.req[ptr_q] ? ptr_q : ~ptr_q;
   assign w_in0  = win ? bus.p1_in0    : bus.p0_in0;
   assign w_in1  = win ? bus.p1_in1    : bus.p0_in1;
   assign w_acc  = win ? bus.p1_acc    : bus.p0_acc;
   assign w_long = win ? bus.p1_long   : bus.p0_long;
   assign w_sgn  = win ? bus.p1_signed : bus.p0_signed;

   logic [63:0] pp0, pp1, acc_iter, acc_fix;
   logic [31:0] bf_next;
   logic        iter_last;
   logic        kill_own;

   assign pp0      = bf_q[0] ? mcand_q : 64'b0;
   assign pp1      = bf_q[1] ? {mcand_q[62:0], 1'b0} : 64'b0;
   assign acc_iter = acc_q + pp0 + pp1;
   assign bf_next  = {2'b00, bf_q[31:2]};
   assign acc_fix  = fixup(acc_q, in0_q, in1_q, long_q, sgn_q);
   assign kill_own = bus.kill[owner_q];
`ifdef MULT_EARLY_TERM_EN
   assign iter_last = (bf_next == 32'b0);
`else
   assign iter_last = (cnt_q == 4'd15);
`endif

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      owner_d  = owner_q;
      gnt_d    = 2'b00;
      done_d   = 2'b00;
      result_d = result_q;
      res_n_d  = res_n_q;
      res_z_d  = res_z_q;
      bf_d     = bf_q;
      in0_d    = in0_q;
      in1_d    = in1_q;
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      long_d   = long_q;
      sgn_d    = sgn_q;
`ifndef MULT_EARLY_TERM_EN
      cnt_d    = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (|bus.req) begin
               bf_d    = w_in0;
               in0_d   = w_in0;
               in1_d   = w_in1;
               mcand_d = {32'b0, w_in1};
               acc_d   = w_long ? w_acc : {32'b0, w_acc[31:0]};
               long_d  = w_long;
               sgn_d   = w_sgn;
               gnt_d   = win ? 2'b10 : 2'b01;
               owner_d = win;
               ptr_d   = ~win;
               state_d = ITER;
`ifndef MULT_EARLY_TERM_EN
               cnt_d   = 4'd0;
`endif
            end
         end
         ITER: begin
            if (kill_own) begin
               state_d = IDLE;
            end else begin
               acc_d   = acc_iter;
               bf_d    = bf_next;
               mcand_d = {mcand_q[61:0], 2'b00};
`ifndef MULT_EARLY_TERM_EN
               cnt_d   = cnt_q + 4'd1;
`endif
               if (iter_last)
                  state_d = FIX;
            end
         end
         FIX: begin
            // Kill wins over completion: result and flags stay untouched.
            if (kill_own) begin
               state_d = IDLE;
            end else begin
               result_d = acc_fix;
               res_n_d  = long_q ? acc_fix[63] : acc_fix[31];
               res_z_d  = (acc_fix == 64'b0);
               done_d   = owner_q ? 2'b10 : 2'b01;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         ptr_q    <= 1'b0;
         owner_q  <= 1'b0;
         gnt_q    <= 2'b00;
         done_q   <= 2'b00;
         result_q <= 64'b0;
         res_n_q  <= 1'b0;
         res_z_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         owner_q  <= owner_d;
         gnt_q    <= gnt_d;
         done_q   <= done_d;
         result_q <= result_d;
         res_n_q  <= res_n_d;
         res_z_q  <= res_z_d;
      end
   end

   always_ff @(posedge clk) begin
      bf_q    <= bf_d;
      in0_q   <= in0_d;
      in1_q   <= in1_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      long_q  <= long_d;
      sgn_q   <= sgn_d;
`ifndef MULT_EARLY_TERM_EN
      cnt_q   <= cnt_d;
`endif
   end

   assign bus.gnt    = gnt_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.res_n  = res_n_q;
   assign bus.res_z  = res_z_q;
   assign bus.busy   = (state_q != IDLE);
   assign bus.owner  = owner_q;

endmodule

// File: tb/tb_mul_seq_arb.sv
// tb_mul_seq_arb -- self-checking bench for mul_seq_arb. Expected
// results come from a behavioural multiply model and are queued at
// grant time, then popped when the matching done pulse appears.
// Honours MULT_EARLY_TERM_EN for the expected latency.
module tb_mul_seq_arb;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_bad = 0;

   mul_seq_arb_if bus ();

   mul_seq_arb dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [1:0]  port;
      logic [63:0] res;
      logic        n;
      logic        z;
      int          lat;
   } exp_t;

   exp_t sb[$];

   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic [63:0] c, input logic lng,
                                         input logic sg);
      logic signed [63:0] sa, sb_;
      logic [63:0] p;
      if (!lng) begin
         p = {32'b0, a * b + c[31:0]};
      end else if (sg) begin
         sa  = $signed({{32{a[31]}}, a});
         sb_ = $signed({{32{b[31]}}, b});
         p   = sa * sb_ + c;
      end else begin
         p = {32'b0, a} * {32'b0, b} + c;
      end
      return p;
   endfunction

   // Accept-to-done distance in cycles.
   function automatic int model_lat(input logic [31:0] a);
`ifdef MULT_EARLY_TERM_EN
      int h;
      h = 0;
      for (int i = 0; i < 32; i++) if (a[i]) h = i + 1;
      return (h <= 2) ? 2 : ((h + 1) / 2) + 1;
`else
      return 17;
`endif
   endfunction

   task automatic push_exp(input int p, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] c, input logic lng, input logic sg);
      exp_t e;
      e.port = (p == 0) ? 2'b01 : 2'b10;
      e.res  = model(a, b, c, lng, sg);
      e.n    = lng ? e.res[63] : e.res[31];
      e.z    = (e.res == 64'b0);
      e.lat  = model_lat(a);
      sb.push_back(e);
   endtask

   task automatic set_ops(input int p, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] c, input logic lng, input logic sg);
      if (p == 0) begin
         bus.p0_in0 = a; bus.p0_in1 = b; bus.p0_acc = c;
         bus.p0_long = lng; bus.p0_signed = sg;
      end else begin
         bus.p1_in0 = a; bus.p1_in1 = b; bus.p1_acc = c;
         bus.p1_long = lng; bus.p1_signed = sg;
      end
   endtask

   task automatic wait_gnt(output logic [1:0] g, output int gc);
      g  = 2'b00;
      gc = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.gnt != 2'b00) begin
            g  = bus.gnt;
            gc = cyc;
            break;
         end
      end
   endtask

   task automatic wait_done(output logic [1:0] d, output logic [63:0] r,
                            output logic n, output logic z, output int dc);
      d = 2'b00; r = '0; n = 1'b0; z = 1'b0; dc = -1000;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.done != 2'b00) begin
            d = bus.done; r = bus.result; n = bus.res_n; z = bus.res_z; dc = cyc;
            break;
         end
      end
   endtask

   task automatic test_reset;
      n_vec++;
      if ({bus.gnt, bus.done, bus.busy, bus.owner} !== 6'b0) begin
         n_bad++;
         $display("FAIL reset_ctrl: gnt=%b done=%b busy=%b owner=%b, required all 0",
                  bus.gnt, bus.done, bus.busy, bus.owner);
      end
      n_vec++;
      if ({bus.result, bus.res_n, bus.res_z} !== {64'b0, 1'b0, 1'b1}) begin
         n_bad++;
         $display("FAIL reset_res: result=%h n=%b z=%b, required 0/0/1",
                  bus.result, bus.res_n, bus.res_z);
      end
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      n_vec++;
      if (bus.busy !== 1'b0) begin
         n_bad++;
         $display("FAIL idle_busy: busy=%b, required 0", bus.busy);
      end
   endtask

   task automatic test_long_unsigned;
      logic [1:0] g, d; logic [63:0] r; logic fn, fz; int gc, dc; exp_t e;
      set_ops(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0, 1'b1, 1'b0);
      bus.req = 2'b01;
      wait_gnt(g, gc);
      bus.req = 2'b00;
      n_vec++;
      if (g !== 2'b01) begin n_bad++; $display("FAIL lu_gnt: gnt=%b, required 01", g); end
      push_exp(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0, 1'b1, 1'b0);
      n_vec++;
      if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL lu_busy: busy=%b, required 1", bus.busy); end
      wait_done(d, r, fn, fz, dc);
      e = sb.pop_front();
      n_vec++;
      if ({d, r, fn, fz} !== {e.port, e.res, e.n, e.z} || r !== 64'hFFFFFFFE00000001) begin
         n_bad++;
         $display("FAIL lu_res: done=%b result=%h n=%b z=%b, required done=%b result=%h n=%b z=%b",
                  d, r, fn, fz, e.port, e.res, e.n, e.z);
      end
      n_vec++;
      if (dc - gc !== 17) begin n_bad++; $display("FAIL lu_lat: latency=%0d, required 17", dc - gc); end
   endtask

   task automatic test_long_signed;
      logic [1:0] g, d; logic [63:0] r; logic fn, fz; int gc, dc; exp_t e;
      set_ops(1, 32'hFFFFFFFF, 32'h2, 64'h0, 1'b1, 1'b1);
      bus.req = 2'b10;
      wait_gnt(g, gc);
      bus.req = 2'b00;
      n_vec++;
      if (g !== 2'b10) begin n_bad++; $display("FAIL ls_gnt: gnt=%b, required 10", g); end
      push_exp(1, 32'hFFFFFFFF, 32'h2, 64'h0, 1'b1, 1'b1);
      wait_done(d, r, fn, fz, dc);
      e = sb.pop_front();
      n_vec++;
      if ({d, r, fn, fz} !== {e.port, e.res, e.n, e.z} || r !== 64'hFFFFFFFFFFFFFFFE) begin
         n_bad++;
         $display("FAIL ls_res: done=%b result=%h n=%b z=%b, required done=%b result=%h n=%b z=%b",
                  d, r, fn, fz, e.port, e.res, e.n, e.z);
      end
      n_vec++;
      if (bus.owner !== 1'b1) begin n_bad++; $display("FAIL ls_owner: owner=%b, required 1", bus.owner); end
   endtask

   task automatic test_short_mla;
      logic [1:0] g, d; logic [63:0] r; logic fn, fz; int gc, dc; exp_t e;
      logic [31:0] ta[3]; logic [31:0] tb[3]; logic [63:0] tc[3];
      ta[0] = 32'd3;        tb[0] = 32'd5; tc[0] = 64'hA;
      ta[1] = 32'h80000000; tb[1] = 32'd1; tc[1] = 64'hFFFFFFFF_0000000A;
      ta[2] = 32'd0;        tb[2] = 32'd5; tc[2] = 64'h0;
      for (int k = 0; k < 3; k++) begin
         set_ops(0, ta[k], tb[k], tc[k], 1'b0, 1'b1);
         bus.req = 2'b01;
         wait_gnt(g, gc);
         bus.req = 2'b00;
         n_vec++;
         if (g !== 2'b01) begin n_bad++; $display("FAIL sm_gnt[%0d]: gnt=%b, required 01", k, g); end
         push_exp(0, ta[k], tb[k], tc[k], 1'b0, 1'b1);
         wait_done(d, r, fn, fz, dc);
         e = sb.pop_front();
         n_vec++;
         if ({d, r, fn, fz} !== {e.port, e.res, e.n, e.z}) begin
            n_bad++;
            $display("FAIL sm_res[%0d]: done=%b result=%h n=%b z=%b, required done=%b result=%h n=%b z=%b",
                     k, d, r, fn, fz, e.port, e.res, e.n, e.z);
         end
         n_vec++;
         if (dc - gc !== e.lat) begin
            n_bad++;
            $display("FAIL sm_lat[%0d]: latency=%0d, required %0d", k, dc - gc, e.lat);
         end
      end
   endtask

   task automatic test_arbitration;
      logic [1:0] g, d; logic [63:0] r; logic fn, fz; int gc, dc; exp_t e;
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      set_ops(0, 32'h0000000F, 32'h11, 64'h5, 1'b0, 1'b0);
      set_ops(1, 32'h00010000, 32'h3, 64'hFFFFFFFF_00000001, 1'b1, 1'b0);
      for (int round = 0; round < 2; round++) begin
         bus.req = 2'b11;
         wait_gnt(g, gc);
         bus.req = 2'b10;
         n_vec++;
         if (g !== 2'b01) begin n_bad++; $display("FAIL arb_first[%0d]: gnt=%b, required 01", round, g); end
         push_exp(0, 32'h0000000F, 32'h11, 64'h5, 1'b0, 1'b0);
         wait_done(d, r, fn, fz, dc);
         e = sb.pop_front();
         n_vec++;
         if ({d, r, fn, fz} !== {e.port, e.res, e.n, e.z}) begin
            n_bad++;
            $display("FAIL arb_p0[%0d]: done=%b result=%h, required done=%b result=%h",
                     round, d, r, e.port, e.res);
         end
         // The pending port-1 request is taken on the edge after done.
         wait_gnt(g, gc);
         bus.req = 2'b00;
         n_vec++;
         if (g !== 2'b10 || gc !== dc + 1) begin
            n_bad++;
            $display("FAIL arb_second[%0d]: gnt=%b at %0d, required 10 at %0d", round, g, gc, dc + 1);
         end
         push_exp(1, 32'h00010000, 32'h3, 64'hFFFFFFFF_00000001, 1'b1, 1'b0);
         wait_done(d, r, fn, fz, dc);
         e = sb.pop_front();
         n_vec++;
         if ({d, r, fn, fz} !== {e.port, e.res, e.n, e.z} || dc - gc !== e.lat) begin
            n_bad++;
            $display("FAIL arb_p1[%0d]: done=%b result=%h lat=%0d, required done=%b result=%h lat=%0d",
                     round, d, r, dc - gc, e.port, e.res, e.lat);
         end
      end
   endtask

   task automatic test_kill;
      logic [1:0] g, d; logic [63:0] r, prev; logic fn, fz, seen; int gc, dc; exp_t e;
      set_ops(0, 32'hFFFFFFFF, 32'h7, 64'h0, 1'b1, 1'b0);
      bus.req = 2'b01;
      wait_gnt(g, gc);
      bus.req = 2'b00;
      prev = bus.result;
      repeat (3) @(negedge clk);
      bus.kill = 2'b01;
      @(negedge clk);
      bus.kill = 2'b00;
      n_vec++;
      if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL kill_busy: busy=%b, required 0", bus.busy); end
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (bus.done != 2'b00) seen = 1'b1;
      end
      n_vec++;
      if (seen !== 1'b0) begin n_bad++; $display("FAIL kill_done: done seen=%b, required 0", seen); end
      n_vec++;
      if (bus.result !== prev) begin
         n_bad++;
         $display("FAIL kill_result: result=%h, required %h", bus.result, prev);
      end
      // Kill aimed at the non-owner must not disturb the operation.
      set_ops(0, 32'hFFFF0001, 32'h80000003, 64'h1111, 1'b1, 1'b1);
      bus.req = 2'b01;
      wait_gnt(g, gc);
      bus.req = 2'b00;
      push_exp(0, 32'hFFFF0001, 32'h80000003, 64'h1111, 1'b1, 1'b1);
      repeat (2) @(negedge clk);
      bus.kill = 2'b10;
      @(negedge clk);
      bus.kill = 2'b00;
      wait_done(d, r, fn, fz, dc);
      e = sb.pop_front();
      n_vec++;
      if ({d, r, fn, fz} !== {e.port, e.res, e.n, e.z} || dc - gc !== e.lat) begin
         n_bad++;
         $display("FAIL kill_other: done=%b result=%h n=%b z=%b lat=%0d, required done=%b result=%h n=%b z=%b lat=%0d",
                  d, r, fn, fz, dc - gc, e.port, e.res, e.n, e.z, e.lat);
      end
   endtask

   task automatic test_reset_mid;
      logic [1:0] g, d; logic [63:0] r; logic fn, fz; int gc, dc, rc; exp_t e;
      set_ops(1, 32'hDEADBEEF, 32'h00000123, 64'h0, 1'b1, 1'b0);
      bus.req = 2'b10;
      wait_gnt(g, gc);
      n_vec++;
      if (g !== 2'b10) begin n_bad++; $display("FAIL rm_gnt: gnt=%b, required 10", g); end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      n_vec++;
      if ({bus.gnt, bus.done, bus.busy, bus.owner, bus.result, bus.res_n, bus.res_z}
          !== {2'b00, 2'b00, 1'b0, 1'b0, 64'b0, 1'b0, 1'b1}) begin
         n_bad++;
         $display("FAIL rm_async: gnt=%b done=%b busy=%b owner=%b result=%h n=%b z=%b, required reset values",
                  bus.gnt, bus.done, bus.busy, bus.owner, bus.result, bus.res_n, bus.res_z);
      end
      @(negedge clk);
      rst = 1'b0;
      rc = cyc;
      wait_gnt(g, gc);
      bus.req = 2'b00;
      n_vec++;
      if (g !== 2'b10 || gc !== rc + 1) begin
         n_bad++;
         $display("FAIL rm_regrant: gnt=%b at %0d, required 10 at %0d", g, gc, rc + 1);
      end
      push_exp(1, 32'hDEADBEEF, 32'h00000123, 64'h0, 1'b1, 1'b0);
      wait_done(d, r, fn, fz, dc);
      e = sb.pop_front();
      n_vec++;
      if ({d, r, fn, fz} !== {e.port, e.res, e.n, e.z}) begin
         n_bad++;
         $display("FAIL rm_res: done=%b result=%h, required done=%b result=%h", d, r, e.port, e.res);
      end
   endtask

   initial begin
      bus.req  = 2'b00;
      bus.kill = 2'b00;
      set_ops(0, 32'h0, 32'h0, 64'h0, 1'b0, 1'b0);
      set_ops(1, 32'h0, 32'h0, 64'h0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      test_reset;
      test_long_unsigned;
      test_long_signed;
      test_short_mla;
      test_arbitration;
      test_kill;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/mul_seq_arb.md
# mul_seq_arb

Shared-multiplier controller that arbitrates two requesters onto one radix-4 (2 bits/cycle) iterative multiply engine. It sequences 32×32 MUL/MLA and 32×32→64 UMULL/UMLAL/SMULL/SMLAL. It sits beside the Execute stage: port 0 serves the Execute multiply path and port 1 serves the secondary requester (coprocessor/long-multiply issue). The block returns a 64-bit result with N/Z flags and a per-port done pulse.

## Interface
- No parameters; widths fixed (32-bit operands, 64-bit accumulator/result).
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- req  in  2  request per port; bit p = port p
- p0_in0, p1_in0  in  32  multiplier operand (Rm), iterated 2 bits/cycle
- p0_in1, p1_in1  in  32  multiplicand operand (Rs)
- p0_acc, p1_acc  in  64  accumulate value ({RdHi,RdLo} or {32'b0,Rn}; zero for non-accumulate)
- p0_long, p1_long  in  1  1 = 64-bit result; 0 = 32-bit MUL/MLA
- p0_signed, p1_signed  in  1  signed long multiply (ignored when long=0)
- kill  in  2  abort; kill[owner] cancels the in-flight operation
- gnt  out  2  one-cycle pulse: port p's request accepted, operands captured
- done  out  2  one-cycle pulse: result valid for port p
- result  out  64  product; held until next done
- res_n, res_z  out  1  flags of result; held with result
- busy  out  1  engine not IDLE
- owner  out  1  port owning current/last operation

## Operation
- States: IDLE, ITER, FIX. Registers: bitfield[31:0], mcand[63:0], acc[63:0], ptr (round-robin), latched long/signed/in0[31]/in1[31].
- IDLE: if any req, winner = ptr port if it requests, else the other. At the edge: capture winner's operands; bitfield←in0, mcand←{32'b0,in1}, acc←long ? p_acc : {32'b0,p_acc[31:0]}. Then gnt[winner]←1, owner←winner, ptr←~winner, →ITER.
- ITER: acc += (bitfield[0]?mcand:0) + (bitfield[1]?mcand<<1:0), mod 2^64; bitfield>>=2; mcand<<=2. Leave to FIX per Configuration.
- FIX: if long&signed: acc -= (in1[31]?{in0,32'b0}:0) + (in0[31]?{in1,32'b0}:0), mod 2^64. If !long: upper 32 bits forced 0. At the edge: result←acc; res_n←long?acc[63]:acc[31]; res_z←(long?acc:acc[31:0])==0; done[owner]←1; →IDLE.
- Requester holds req and operands stable until gnt and drops req in the gnt cycle; req still high after the gnt cycle is a new request.
- kill[owner] in ITER or FIX: →IDLE at next edge, no done, result/flags unchanged. kill[!owner] and kill in IDLE are ignored; kill has priority over FIX completion.
- Priority ptr alternates per grant. Simultaneous requests: ptr port wins and the loser stays pending.

## Timing
- Reset (async, immediate) values: gnt=0, done=0, result=0, res_n=0, res_z=1, busy=0, owner=0, ptr=0, state IDLE. Reset mid-operation discards it silently.
- Accept edge E0. Let N = ITER cycles. done rises at edge E0+N+1, for exactly one cycle.
- gnt high in the cycle after E0; busy high from E0 until the done edge.
- Back-to-back: IDLE is reachable in the done cycle, so the next accept edge is E0+N+2. Minimum issue interval is N+2.
- All outputs are registered; no combinational input→output path.

## Configuration
- MULT_EARLY_TERM_EN defined: ITER exits after the cycle in which the shifted bitfield becomes 0. N = max(1, ceil(h/2)), where h = index of highest set bit of in0 + 1 (in0=0 → N=1).
- Undefined: N = 16 always. Latency is fixed at 17 cycles accept-to-done.
- Results are identical in both builds.

## Test plan
- p0: in0=in1=0xFFFFFFFF, acc=0, long=1, signed=0 → result=0xFFFFFFFE00000001, res_n=1, res_z=0, done[0] at E0+17 (both builds).
- p1: in0=0xFFFFFFFF, in1=2, acc=0, long=1, signed=1 → result=0xFFFFFFFFFFFFFFFE, res_n=1, done[1] only.
- p0: in0=3, in1=5, acc=0xA, long=0 → result=0x19, res_z=0. done[0] at E0+2 with MULT_EARLY_TERM_EN, at E0+17 without.
- req=2'b11 after reset → gnt[0] first; p1 accepted at edge after done[0]; gnt[1] follows; then ptr=0. Re-raise both → port 0 wins again.
- kill[owner] during ITER → busy low next edge, no done, result retains previous value. kill[!owner] → operation completes normally.
- rst pulsed mid-ITER → all outputs at reset values immediately. Held req=2'b10 re-granted to port 1 on the first edge after rst falls.
